// File: rtl/edge_waveform_gen.sv
// Slew-limited edge waveform source: rise/fall command pulses ramp a quantized level code.
// Define WREAL_OUT_EN to add a real-valued a_out port scaled by FULL_SCALE.
module edge_waveform_gen #(
    parameter int  CODE_W     = 8,
    parameter int  LOW_CODE   = 0,
    parameter int  HIGH_CODE  = 200,
    parameter int  STEP       = 50,
    parameter int  CNT_W      = 16
`ifdef WREAL_OUT_EN
    ,
    parameter real FULL_SCALE = 1.0
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rise_req,
    input  logic              fall_req,
    output logic [CODE_W-1:0] a_code,
    output logic              busy,
    output logic              rise_done,
    output logic              fall_done,
    output logic              req_err,
    output logic [CNT_W-1:0]  edge_cnt
`ifdef WREAL_OUT_EN
    ,
    output real               a_out
`endif
);

    localparam int SUM_W = CODE_W + 2;
    localparam logic signed [SUM_W-1:0] STEP_S = SUM_W'(STEP);
    localparam logic signed [SUM_W-1:0] HIGH_S = SUM_W'(HIGH_CODE);
    localparam logic signed [SUM_W-1:0] LOW_S  = SUM_W'(LOW_CODE);
    localparam logic [CODE_W-1:0]       HIGH_C = CODE_W'(HIGH_CODE);
    localparam logic [CODE_W-1:0]       LOW_C  = CODE_W'(LOW_CODE);

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_RISING  = 2'd1,
        S_HIGH    = 2'd2,
        S_FALLING = 2'd3
    } state_t;

    state_t              state_q;
    logic [CODE_W-1:0]   a_code_q;
    logic                busy_q;
    logic                rise_done_q;
    logic                fall_done_q;
    logic                req_err_q;
    logic [CNT_W-1:0]    edge_cnt_q;

    // Candidate next levels, computed with headroom so neither direction can wrap.
    logic signed [SUM_W-1:0] up_d;
    logic signed [SUM_W-1:0] dn_d;
    logic                    up_hit;
    logic                    dn_hit;

    assign up_d   = signed'({2'b00, a_code_q}) + STEP_S;
    assign dn_d   = signed'({2'b00, a_code_q}) - STEP_S;
    assign up_hit = (up_d >= HIGH_S);
    assign dn_hit = (dn_d <= LOW_S);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOW;
            a_code_q    <= LOW_C;
            busy_q      <= 1'b0;
            rise_done_q <= 1'b0;
            fall_done_q <= 1'b0;
            req_err_q   <= 1'b0;
            edge_cnt_q  <= '0;
        end else begin
            rise_done_q <= 1'b0;
            fall_done_q <= 1'b0;
            req_err_q   <= 1'b0;
            if (rise_req && fall_req) begin
                // Conflicting command freezes everything, including an active ramp.
                req_err_q <= 1'b1;
            end else begin
                case (state_q)
                    S_LOW: begin
                        if (rise_req) begin
                            state_q <= S_RISING;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (fall_req) begin
                            state_q <= S_FALLING;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_RISING: begin
                        if (fall_req) begin
                            state_q <= S_FALLING;
                        end else if (up_hit) begin
                            a_code_q    <= HIGH_C;
                            state_q     <= S_HIGH;
                            busy_q      <= 1'b0;
                            rise_done_q <= 1'b1;
                            edge_cnt_q  <= edge_cnt_q + 1'b1;
                        end else begin
                            a_code_q <= up_d[CODE_W-1:0];
                        end
                    end
                    S_FALLING: begin
                        if (rise_req) begin
                            state_q <= S_RISING;
                        end else if (dn_hit) begin
                            a_code_q    <= LOW_C;
                            state_q     <= S_LOW;
                            busy_q      <= 1'b0;
                            fall_done_q <= 1'b1;
                            edge_cnt_q  <= edge_cnt_q + 1'b1;
                        end else begin
                            a_code_q <= dn_d[CODE_W-1:0];
                        end
                    end
                    default: begin
                        state_q  <= S_LOW;
                        a_code_q <= LOW_C;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign a_code    = a_code_q;
    assign busy      = busy_q;
    assign rise_done = rise_done_q;
    assign fall_done = fall_done_q;
    assign req_err   = req_err_q;
    assign edge_cnt  = edge_cnt_q;

`ifdef WREAL_OUT_EN
    assign a_out = $itor(int'(a_code_q)) * FULL_SCALE / $itor((2 ** CODE_W) - 1);
`endif

endmodule

// File: tb/tb_edge_waveform_gen.sv
// Directed bench for edge_waveform_gen: STEP=50 instance (small counter for wrap) and a
// STEP=60 instance for saturation and mid-ramp reset.
module tb_edge_waveform_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, rise_a = 1'b0, fall_a = 1'b0;
    logic [7:0] code_a;
    logic       busy_a, rd_a, fd_a, err_a;
    logic [2:0] cnt_a;

    logic        rst_b = 1'b1, rise_b = 1'b0, fall_b = 1'b0;
    logic [7:0]  code_b;
    logic        busy_b, rd_b, fd_b, err_b;
    logic [15:0] cnt_b;

    edge_waveform_gen #(
        .CODE_W(8), .LOW_CODE(0), .HIGH_CODE(200), .STEP(50), .CNT_W(3)
    ) dut_a (
        .clk(clk), .rst(rst_a), .rise_req(rise_a), .fall_req(fall_a),
        .a_code(code_a), .busy(busy_a), .rise_done(rd_a), .fall_done(fd_a),
        .req_err(err_a), .edge_cnt(cnt_a)
    );

    edge_waveform_gen #(
        .CODE_W(8), .LOW_CODE(0), .HIGH_CODE(200), .STEP(60), .CNT_W(16)
    ) dut_b (
        .clk(clk), .rst(rst_b), .rise_req(rise_b), .fall_req(fall_b),
        .a_code(code_b), .busy(busy_b), .rise_done(rd_b), .fall_done(fd_b),
        .req_err(err_b), .edge_cnt(cnt_b)
    );

    typedef struct {
        logic rst;
        logic rise;
        logic fall;
        int   code;
        logic busy;
        logic rd;
        logic fd;
        logic err;
        int   cnt;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic r, logic ri, logic fa, int code, logic b,
                                logic rd, logic fd, logic er, int cnt);
        vec_t v;
        v.rst = r; v.rise = ri; v.fall = fa; v.code = code; v.busy = b;
        v.rd = rd; v.fd = fd; v.err = er; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one vector mid-cycle, let one rising edge pass, then compare.
    task automatic run_vec(input vec_t v, input int idx, input bit on_b);
        int code, cnt;
        logic b, rd, fd, er;
        @(negedge clk);
        if (on_b) begin rst_b = v.rst; rise_b = v.rise; fall_b = v.fall; end
        else      begin rst_a = v.rst; rise_a = v.rise; fall_a = v.fall; end
        @(posedge clk);
        #1;
        if (on_b) begin
            code = int'(code_b); b = busy_b; rd = rd_b; fd = fd_b; er = err_b; cnt = int'(cnt_b);
        end else begin
            code = int'(code_a); b = busy_a; rd = rd_a; fd = fd_a; er = err_a; cnt = int'(cnt_a);
        end
        $display("[TB] %s vec %0d rst=%0b rise=%0b fall=%0b -> code=%0d busy=%0b rd=%0b fd=%0b err=%0b cnt=%0d",
                 on_b ? "B" : "A", idx, v.rst, v.rise, v.fall, code, b, rd, fd, er, cnt);
        chk(on_b ? "b_code" : "a_code", idx, code, v.code);
        chk(on_b ? "b_busy" : "a_busy", idx, int'(b), int'(v.busy));
        chk(on_b ? "b_rise_done" : "a_rise_done", idx, int'(rd), int'(v.rd));
        chk(on_b ? "b_fall_done" : "a_fall_done", idx, int'(fd), int'(v.fd));
        chk(on_b ? "b_req_err" : "a_req_err", idx, int'(er), int'(v.err));
        chk(on_b ? "b_edge_cnt" : "a_edge_cnt", idx, cnt, v.cnt);
    endtask

    initial begin
        // STEP=50: reset, idle, full rise, fall with same-direction repeat,
        // reversal mid-rise, conflicting requests in LOW and mid-ramp.
        va.push_back(mk(1,0,0,   0,0,0,0,0,0));
        va.push_back(mk(1,0,0,   0,0,0,0,0,0));
        for (int i = 0; i < 5; i++) va.push_back(mk(0,0,0, 0,0,0,0,0,0));
        va.push_back(mk(0,1,0,   0,1,0,0,0,0));
        va.push_back(mk(0,0,0,  50,1,0,0,0,0));
        va.push_back(mk(0,0,0, 100,1,0,0,0,0));
        va.push_back(mk(0,0,0, 150,1,0,0,0,0));
        va.push_back(mk(0,0,0, 200,0,1,0,0,1));
        va.push_back(mk(0,0,0, 200,0,0,0,0,1));
        va.push_back(mk(0,1,0, 200,0,0,0,0,1));
        va.push_back(mk(0,0,1, 200,1,0,0,0,1));
        va.push_back(mk(0,0,0, 150,1,0,0,0,1));
        va.push_back(mk(0,0,1, 100,1,0,0,0,1));
        va.push_back(mk(0,0,0,  50,1,0,0,0,1));
        va.push_back(mk(0,0,0,   0,0,0,1,0,2));
        va.push_back(mk(0,0,0,   0,0,0,0,0,2));
        va.push_back(mk(0,0,1,   0,0,0,0,0,2));
        va.push_back(mk(0,1,0,   0,1,0,0,0,2));
        va.push_back(mk(0,0,0,  50,1,0,0,0,2));
        va.push_back(mk(0,0,0, 100,1,0,0,0,2));
        va.push_back(mk(0,0,1, 100,1,0,0,0,2));
        va.push_back(mk(0,0,0,  50,1,0,0,0,2));
        va.push_back(mk(0,0,0,   0,0,0,1,0,3));
        va.push_back(mk(0,1,1,   0,0,0,0,1,3));
        va.push_back(mk(0,0,0,   0,0,0,0,0,3));
        va.push_back(mk(0,1,0,   0,1,0,0,0,3));
        va.push_back(mk(0,0,0,  50,1,0,0,0,3));
        va.push_back(mk(0,1,1,  50,1,0,0,1,3));
        va.push_back(mk(0,0,0, 100,1,0,0,0,3));
        va.push_back(mk(0,0,0, 150,1,0,0,0,3));
        va.push_back(mk(0,0,0, 200,0,1,0,0,4));

        // STEP=60: saturating last step both ways, then reset mid-ramp.
        vb.push_back(mk(1,0,0,   0,0,0,0,0,0));
        vb.push_back(mk(1,0,0,   0,0,0,0,0,0));
        vb.push_back(mk(0,1,0,   0,1,0,0,0,0));
        vb.push_back(mk(0,0,0,  60,1,0,0,0,0));
        vb.push_back(mk(0,0,0, 120,1,0,0,0,0));
        vb.push_back(mk(0,0,0, 180,1,0,0,0,0));
        vb.push_back(mk(0,0,0, 200,0,1,0,0,1));
        vb.push_back(mk(0,0,1, 200,1,0,0,0,1));
        vb.push_back(mk(0,0,0, 140,1,0,0,0,1));
        vb.push_back(mk(0,0,0,  80,1,0,0,0,1));
        vb.push_back(mk(0,0,0,  20,1,0,0,0,1));
        vb.push_back(mk(0,0,0,   0,0,0,1,0,2));
        vb.push_back(mk(0,1,0,   0,1,0,0,0,2));
        vb.push_back(mk(0,0,0,  60,1,0,0,0,2));
        vb.push_back(mk(0,0,0, 120,1,0,0,0,2));
        vb.push_back(mk(1,0,0,   0,0,0,0,0,0));
        vb.push_back(mk(0,0,0,   0,0,0,0,0,0));
        vb.push_back(mk(0,0,0,   0,0,0,0,0,0));

        for (int i = 0; i < va.size(); i++) run_vec(va[i], i, 1'b0);

        // Four more edges on the 3-bit counter: 4 -> 8, which wraps to 0.
        for (int k = 0; k < 4; k++) begin
            int seen;
            @(negedge clk);
            if (k % 2 == 0) fall_a = 1'b1; else rise_a = 1'b1;
            @(negedge clk);
            fall_a = 1'b0; rise_a = 1'b0;
            seen = 0;
            for (int c = 0; c < 12 && seen == 0; c++) begin
                @(negedge clk);
                if (rd_a || fd_a) seen = 1;
            end
            $display("[TB] A wrap edge %0d done_seen=%0d cnt=%0d", k, seen, cnt_a);
            chk("wrap_done_seen", k, seen, 1);
            chk("wrap_edge_cnt", k, int'(cnt_a), (5 + k) % 8);
        end

        for (int i = 0; i < vb.size(); i++) run_vec(vb[i], i, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
